// File: rtl/accum_tile_sequencer.sv
// Initiator for the 12-lane accumulator tree: issues per-chunk lane products plus the running sum,
// waits out the tree latency, folds the tree output back in and presents the final dot product.
module accum_tile_sequencer #(
    parameter int unsigned TREE_LAT = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_chunks,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [95:0]      act,
    input  logic [95:0]      wgt,
    output logic [191:0]     product,
    output logic [31:0]      partial_sum,
    input  logic [31:0]      acc_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result
);

    localparam int unsigned Lanes  = 12;
    localparam int unsigned WaitW  = (TREE_LAT > 1) ? $clog2(TREE_LAT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TREE_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   chunk_cnt_q, chunk_cnt_d;
    logic [CNT_W-1:0]   chunk_inc;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]        run_sum_q, run_sum_d;
    logic [191:0]       product_q, product_d;
    logic [31:0]        partial_sum_q, partial_sum_d;
    logic [31:0]        result_q, result_d;
    logic [191:0]       lane_prod;

    always_comb begin
        lane_prod = '0;
        for (int i = 0; i < Lanes; i++) begin
            lane_prod[16*i +: 16] = 16'(act[8*i +: 8]) * 16'(wgt[8*i +: 8]);
        end
    end

    assign chunk_inc = chunk_cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        chunk_cnt_d   = chunk_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        run_sum_d     = run_sum_q;
        product_d     = product_q;
        partial_sum_d = partial_sum_q;
        result_d      = result_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_chunks != '0) begin
                        num_d       = num_chunks;
                        chunk_cnt_d = '0;
                        run_sum_d   = '0;
                        state_d     = StIssue;
                    end else begin
                        result_d = '0;
                        state_d  = StDone;
                    end
                end
            end
            StIssue: begin
                if (in_valid) begin
                    product_d     = lane_prod;
                    partial_sum_d = run_sum_q;
                    wait_cnt_d    = '0;
                    state_d       = StWait;
                end
            end
            StWait: begin
                // The tree output is sampled on the TREE_LAT-th edge after the accept edge.
                if (wait_cnt_q == WaitLast) begin
                    run_sum_d   = acc_in;
                    chunk_cnt_d = chunk_inc;
                    if (chunk_inc == num_q) begin
                        result_d = acc_in;
                        state_d  = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            num_q         <= '0;
            chunk_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            run_sum_q     <= '0;
            product_q     <= '0;
            partial_sum_q <= '0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            chunk_cnt_q   <= chunk_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            run_sum_q     <= run_sum_d;
            product_q     <= product_d;
            partial_sum_q <= partial_sum_d;
            result_q      <= result_d;
        end
    end

    assign in_ready    = (state_q == StIssue);
    assign busy        = (state_q != StIdle);
    assign out_valid   = (state_q == StDone);
    assign product     = product_q;
    assign partial_sum = partial_sum_q;
    assign result      = result_q;

endmodule
